// File: rtl/filter2d_pkg.sv
// filter2d_pkg: shared types, widths and the output saturation helper for the 3x3 filter
package filter2d_pkg;
    localparam int COEF_W = 8;
    localparam int PIX_W = 8;
    localparam int ACC_W = 20;
    localparam int NTAP = 9;

    typedef enum logic [1:0] {
        M_CONV = 2'd0,
        M_ABS = 2'd1,
        M_BYPASS = 2'd2,
        M_RSVD = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_SH,
        S_WR,
        S_DONE
    } state_e;

    function automatic logic [PIX_W-1:0] sat_u8(input logic signed [ACC_W-1:0] x);
        return x[ACC_W-1] ? '0 : (|x[ACC_W-2:PIX_W] ? '1 : x[PIX_W-1:0]);
    endfunction
endpackage

// File: rtl/filter2d_linebuf.sv
// filter2d_linebuf: two chained row delays of DEPTH samples, yielding the pixels one and two rows back
module filter2d_linebuf
    import filter2d_pkg::*;
#(
    parameter int DEPTH = 257
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] row1,
    output logic [PIX_W-1:0] row2
);
    localparam int PW = $clog2(DEPTH);

    logic [PIX_W-1:0] line1 [DEPTH];
    logic [PIX_W-1:0] line2 [DEPTH];
    logic [PW-1:0]    ptr;

    // Circular buffers: the slot about to be overwritten holds the sample from DEPTH shifts ago
    assign row1 = line1[ptr];
    assign row2 = line2[ptr];

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (shift)
            ptr <= ptr == PW'(DEPTH - 1) ? '0 : ptr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (shift) begin
            line1[ptr] <= din;
            line2[ptr] <= line1[ptr];
        end
    end
endmodule

// File: rtl/filter2d_lb.sv
// filter2d_lb: 3x3 programmable filter streaming an image through line buffers,
// reading from and writing back to a shared single-port memory.
module filter2d_lb
    import filter2d_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int AW = 17,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = IMG_W * IMG_H,
    parameter int COEF_SHIFT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    mode,
    output logic          busy,
    output logic          finish,
    input  logic          h_write,
    input  logic [3:0]    h_idx,
    input  logic [7:0]    h_data,
    output logic          cs,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic [7:0]    din,
    input  logic [7:0]    dout
);
    localparam int RW = $clog2(IMG_H + 1);
    localparam int CW = $clog2(IMG_W + 1);

    state_e state, state_nx;
    mode_e mode_q;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic signed [COEF_W-1:0] coef [NTAP];
    logic [PIX_W-1:0] win [3][3];
    logic [PIX_W-1:0] row1, row2, sample, tap, result;
    logic [2:0] rv, cv;
    logic signed [ACC_W-1:0] acc, s, mag;
    logic in_img, has_out, last, step;

    assign in_img = r < RW'(IMG_H) && c < CW'(IMG_W);
    assign has_out = r != '0 && c != '0;
    assign last = r == RW'(IMG_H) && c == CW'(IMG_W);
    assign step = !last && ((state == S_SH && !has_out) || state == S_WR);
    assign sample = in_img ? dout : '0;

    filter2d_linebuf #(.DEPTH(IMG_W + 1)) u_lb (
        .clk(clk),
        .reset(reset),
        .shift(state == S_SH),
        .din(sample),
        .row1(row1),
        .row2(row2)
    );

    always_ff @(posedge clk) begin
        state <= reset ? S_IDLE : state_nx;
    end

    always_comb begin
        state_nx = state;
        busy = 1'b0;
        finish = 1'b0;
        cs = 1'b0;
        we = 1'b0;
        addr = '0;
        din = '0;
        case (state)
            S_IDLE: state_nx = start ? S_RD : S_IDLE;
            S_RD: begin
                busy = 1'b1;
                cs = in_img;
                addr = in_img ? rd_ptr : '0;
                state_nx = S_SH;
            end
            S_SH: begin
                busy = 1'b1;
                state_nx = has_out ? S_WR : S_RD;
            end
            S_WR: begin
                busy = 1'b1;
                cs = 1'b1;
                we = 1'b1;
                addr = wr_ptr;
                din = result;
                state_nx = last ? S_DONE : S_RD;
            end
            S_DONE: begin
                finish = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Reads and writes both advance in raster order, so running pointers replace r*IMG_W+c
    always_ff @(posedge clk) begin
        if (reset) begin
            r <= '0;
            c <= '0;
            rd_ptr <= AW'(SRC_BASE);
            wr_ptr <= AW'(DST_BASE);
            mode_q <= M_CONV;
            for (int k = 0; k < NTAP; k++)
                coef[k] <= k == 4 ? COEF_W'(1 << COEF_SHIFT) : '0;
        end else begin
            if (state == S_IDLE && start) begin
                r <= '0;
                c <= '0;
                rd_ptr <= AW'(SRC_BASE);
                wr_ptr <= AW'(DST_BASE);
                mode_q <= mode_e'(mode);
            end
            if (state == S_RD && in_img)
                rd_ptr <= rd_ptr + 1'b1;
            if (state == S_WR)
                wr_ptr <= wr_ptr + 1'b1;
            if (step) begin
                c <= c == CW'(IMG_W) ? '0 : c + 1'b1;
                if (c == CW'(IMG_W))
                    r <= r + 1'b1;
            end
            if (h_write && !busy && h_idx <= 4'd8)
                coef[h_idx] <= h_data;
        end
    end

    // Window columns 0..2 hold image columns c-2..c, rows 0..2 hold image rows r-2..r
    always_ff @(posedge clk) begin
        if (state == S_SH) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= row2;
            win[1][2] <= row1;
            win[2][2] <= sample;
        end
    end

    // Taps are masked by source coordinate, so stale window/buffer contents never leak in
    always_comb begin
        rv = '0;
        cv = '0;
        acc = '0;
        tap = '0;
        for (int i = 0; i < 3; i++) begin
            rv[i] = int'(r) + i >= 2 && int'(r) + i < IMG_H + 2;
            cv[i] = int'(c) + i >= 2 && int'(c) + i < IMG_W + 2;
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                tap = rv[i] && cv[j] ? win[i][j] : '0;
                acc = acc + ACC_W'(coef[3 * i + j]) * ACC_W'($signed({1'b0, tap}));
            end
        end
    end

    assign s = acc >>> COEF_SHIFT;
    assign mag = s[ACC_W-1] ? -s : s;
    assign result = mode_q == M_BYPASS ? win[1][1] : sat_u8(mode_q == M_ABS ? mag : s);
endmodule
